// File: rtl/crc_frame_sched_if.sv
// Handshake bundle between the per-channel sources, the CRC frame scheduler
// and the downstream byte stream.
interface crc_frame_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned RW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [RW-1:0]        out_src;
  logic                 busy;
  logic                 frame_done;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_data, out_valid, out_last, out_src, busy, frame_done
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_data, out_valid, out_last, out_src, busy, frame_done
  );
endinterface

// File: rtl/crc_frame_sched.sv
// Round-robin scheduler sharing one CRC-8 engine between NUM_REQ byte sources;
// emits PAYLOAD_BYTES forwarded bytes followed by their CRC-8 per frame.
module crc_frame_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PAYLOAD_BYTES = 7,
  parameter logic [7:0]  POLY          = 8'h07,
  parameter logic [7:0]  INIT          = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  crc_frame_sched_if.master bus
);
  localparam int unsigned RW       = $clog2(NUM_REQ);
  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_BYTES - 1);
  localparam logic [RW-1:0] LAST_REQ = RW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] grant, grant_nxt;
  logic [RW-1:0] last_grant, last_grant_nxt;
  logic [RW-1:0] rr_pick;
  logic          rr_hit;
  logic [7:0]    crc, crc_nxt;
  logic [7:0]    byte_cnt, byte_cnt_nxt;
  logic          frame_done_q, frame_done_nxt;
  logic          cur_valid;
  logic [7:0]    cur_byte;

  logic [NUM_REQ-1:0] ready_c;
  logic               out_valid_c;
  logic [7:0]         out_data_c;
  logic               out_last_c;

  // One byte folded into the running CRC, MSB first, non-reflected.
  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int b = 0; b < 8; b++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign cur_valid = bus.req_valid[grant];
  assign cur_byte  = bus.req_data[{grant, 3'b000} +: 8];

  // Scan from last_grant+1 upward; the lowest offset with a request wins.
  always_comb begin
    int unsigned   idx;
    logic [RW-1:0] idx_r;
    rr_pick = last_grant;
    rr_hit  = 1'b0;
    idx     = 0;
    idx_r   = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx = 32'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_r = RW'(idx);
      if (bus.req_valid[idx_r]) begin
        rr_pick = idx_r;
        rr_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    crc_nxt        = crc;
    byte_cnt_nxt   = byte_cnt;
    frame_done_nxt = 1'b0;
    ready_c        = '0;
    out_valid_c    = 1'b0;
    out_data_c     = 8'h00;
    out_last_c     = 1'b0;

    unique case (state)
      IDLE: begin
        if (rr_hit) begin
          grant_nxt    = rr_pick;
          crc_nxt      = INIT;
          byte_cnt_nxt = 8'h00;
          state_nxt    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        out_valid_c    = cur_valid;
        out_data_c     = cur_valid ? cur_byte : 8'h00;
        ready_c[grant] = bus.out_ready;
        if (cur_valid && bus.out_ready) begin
          crc_nxt      = crc8_step(crc, cur_byte);
          byte_cnt_nxt = byte_cnt + 8'd1;
          if (byte_cnt == LAST_IDX) state_nxt = CRC;
        end
      end
      CRC: begin
        out_valid_c = 1'b1;
        out_data_c  = crc;
        out_last_c  = 1'b1;
        if (bus.out_ready) begin
          last_grant_nxt = grant;
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset aborts any frame and restores requester 0 priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant        <= '0;
      last_grant   <= LAST_REQ;
      crc          <= INIT;
      byte_cnt     <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      grant        <= grant_nxt;
      last_grant   <= last_grant_nxt;
      crc          <= crc_nxt;
      byte_cnt     <= byte_cnt_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = out_data_c;
  assign bus.out_last   = out_last_c;
  assign bus.out_src    = grant;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;
endmodule
